spi_xfer_queue: RTL

- Command/response queue that sits directly upstream and downstream of the 16-bit SPI master controller. It buffers outgoing words in a TX FIFO and launches one controller transfer per word via start/data_in. It captures each data_out word on new_data into an RX FIFO.
- A CPU-side bus adapter pushes and pops words without tracking per-transfer handshakes.

---
 rtl/spi_xfer_queue.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/spi_xfer_queue.sv
// TX/RX word queue wrapped around a 16-bit SPI master: launches one controller transfer per
// queued TX word, enforces a minimum idle gap and captures each result into an RX FIFO.
module spi_xfer_queue #(
    parameter int unsigned DEPTH_LOG2 = 3,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_enable,
    input  logic [15:0]           i_tx_data,
    input  logic                  i_tx_push,
    output logic                  o_tx_full,
    output logic [DEPTH_LOG2:0]   o_tx_count,
    output logic [15:0]           o_rx_data,
    input  logic                  i_rx_pop,
    output logic                  o_rx_empty,
    output logic [DEPTH_LOG2:0]   o_rx_count,
    output logic                  o_err,
    input  logic                  i_err_clr,
    output logic                  o_active,
    output logic                  o_spi_start,
    output logic [15:0]           o_spi_data_in,
    input  logic                  i_spi_busy,
    input  logic                  i_spi_new_data,
    input  logic [15:0]           i_spi_data_out
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_CNT = DEPTH[DEPTH_LOG2:0];
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = CNT_ONE[DEPTH_LOG2-1:0];
    localparam logic [7:0]            GAP_LOAD = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ISSUE     = 3'd1;
    localparam logic [2:0] S_WAIT_BUSY = 3'd2;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_GAP       = 3'd4;

    logic [2:0]            r_state;
    logic [2:0]            w_state_nxt;
    logic [7:0]            r_gap_cnt;
    logic [7:0]            w_gap_nxt;

    logic [15:0]           r_tx_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_tx_wptr;
    logic [DEPTH_LOG2-1:0] r_tx_rptr;
    logic [DEPTH_LOG2:0]   r_tx_count;
    logic [DEPTH_LOG2:0]   w_tx_count_nxt;
    logic                  r_tx_full;

    logic [15:0]           r_rx_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_rx_wptr;
    logic [DEPTH_LOG2-1:0] r_rx_rptr;
    logic [DEPTH_LOG2:0]   r_rx_count;
    logic [DEPTH_LOG2:0]   w_rx_count_nxt;
    logic                  r_rx_empty;
    logic [15:0]           r_rx_data;
    logic [15:0]           w_rx_data_nxt;

    logic                  r_err;
    logic [15:0]           r_spi_data_in;

    logic                  w_tx_push_ok;
    logic                  w_rx_pop_ok;
    logic                  w_launch;
    logic                  w_capture;
    logic                  w_err_set;

    assign w_tx_push_ok = i_tx_push & ~r_tx_full;
    assign w_rx_pop_ok  = i_rx_pop & ~r_rx_empty;
    assign w_err_set    = (i_tx_push & r_tx_full) | (i_rx_pop & r_rx_empty);

    // RX space is reserved at launch, so a capture can never find RX full.
    assign w_launch  = (r_state == S_IDLE) & i_enable & (r_tx_count != '0) &
                       (r_rx_count != FULL_CNT);
    assign w_capture = (r_state == S_WAIT_DONE) & i_spi_new_data;

    always_comb begin
        w_state_nxt = r_state;
        w_gap_nxt   = r_gap_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_launch) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (i_spi_busy) begin
                    w_state_nxt = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (i_spi_new_data) begin
                    if (GAP_CYCLES != 0) begin
                        w_state_nxt = S_GAP;
                        w_gap_nxt   = GAP_LOAD;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                if (r_gap_cnt == 8'd0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_gap_nxt = r_gap_cnt - 8'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_tx_count_nxt = r_tx_count;
        if (w_tx_push_ok && !w_launch) begin
            w_tx_count_nxt = r_tx_count + CNT_ONE;
        end else if (!w_tx_push_ok && w_launch) begin
            w_tx_count_nxt = r_tx_count - CNT_ONE;
        end
    end

    always_comb begin
        w_rx_count_nxt = r_rx_count;
        if (w_capture && !w_rx_pop_ok) begin
            w_rx_count_nxt = r_rx_count + CNT_ONE;
        end else if (!w_capture && w_rx_pop_ok) begin
            w_rx_count_nxt = r_rx_count - CNT_ONE;
        end
    end

    // First-word-fall-through head; keeps its last value once RX drains.
    always_comb begin
        w_rx_data_nxt = r_rx_data;
        if (w_rx_pop_ok) begin
            if (r_rx_count > CNT_ONE) begin
                w_rx_data_nxt = r_rx_mem[r_rx_rptr + PTR_ONE];
            end else if (w_capture) begin
                w_rx_data_nxt = i_spi_data_out;
            end
        end else if (r_rx_empty && w_capture) begin
            w_rx_data_nxt = i_spi_data_out;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_gap_cnt     <= 8'd0;
            r_tx_wptr     <= '0;
            r_tx_rptr     <= '0;
            r_tx_count    <= '0;
            r_tx_full     <= 1'b0;
            r_rx_wptr     <= '0;
            r_rx_rptr     <= '0;
            r_rx_count    <= '0;
            r_rx_empty    <= 1'b1;
            r_rx_data     <= 16'h0000;
            r_err         <= 1'b0;
            r_spi_data_in <= 16'h0000;
        end else begin
            r_state    <= w_state_nxt;
            r_gap_cnt  <= w_gap_nxt;
            r_tx_count <= w_tx_count_nxt;
            r_tx_full  <= (w_tx_count_nxt == FULL_CNT);
            r_rx_count <= w_rx_count_nxt;
            r_rx_empty <= (w_rx_count_nxt == '0);
            r_rx_data  <= w_rx_data_nxt;
            if (w_tx_push_ok) begin
                r_tx_wptr <= r_tx_wptr + PTR_ONE;
            end
            if (w_launch) begin
                r_tx_rptr     <= r_tx_rptr + PTR_ONE;
                r_spi_data_in <= r_tx_mem[r_tx_rptr];
            end
            if (w_capture) begin
                r_rx_wptr <= r_rx_wptr + PTR_ONE;
            end
            if (w_rx_pop_ok) begin
                r_rx_rptr <= r_rx_rptr + PTR_ONE;
            end
            // Clear wins over a same-cycle error event.
            if (i_err_clr) begin
                r_err <= 1'b0;
            end else if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_tx_push_ok) begin
            r_tx_mem[r_tx_wptr] <= i_tx_data;
        end
        if (w_capture) begin
            r_rx_mem[r_rx_wptr] <= i_spi_data_out;
        end
    end

    assign o_tx_full     = r_tx_full;
    assign o_tx_count    = r_tx_count;
    assign o_rx_data     = r_rx_data;
    assign o_rx_empty    = r_rx_empty;
    assign o_rx_count    = r_rx_count;
    assign o_err         = r_err;
    assign o_active      = (r_state != S_IDLE);
    assign o_spi_start   = (r_state == S_ISSUE);
    assign o_spi_data_in = r_spi_data_in;

endmodule
